pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the RV32I fetch stage, successor to the plain PC register. It holds the current fetch address and selects the next one from sequential increment, branch/jump redirect or trap redirect. It also runs a valid/ready fetch handshake toward instruction memory, stalls on pipeline hazards, and flags misaligned control-transfer targets. It sits between the branch/trap logic and the instruction memory port.

## Interface
- XLEN, 32, address width in bits
- RESET_VECTOR, 32'h0100_0000, PC value loaded on reset
- ILEN_BYTES, 4, sequential increment in bytes
- ALIGN_BYTES, 4, required target alignment (2 or 4)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- stall  in  1  hold PC and suppress fetch request
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  XLEN  branch/jump destination
- trap_valid  in  1  trap entry or return this cycle
- trap_target  in  XLEN  trap vector / return address
- fetch_valid  out  1  fetch request for address pc
- fetch_ready  in  1  instruction memory accepts request
- pc  out  XLEN  current fetch address (registered)
- pc_plus  out  XLEN  pc + ILEN_BYTES (combinational)
- misalign_valid  out  1  one-cycle pulse: misaligned redirect detected
- misalign_addr  out  XLEN  offending redirect target
- fetch_count  out  32  number of accepted fetch handshakes

## Operation
- States:
  - BOOT: first cycle after reset release
  - RUN: normal fetch
  - FAULT: waiting for trap after a misaligned redirect
- Reset (asynchronous, reset=0):
  - state=BOOT, pc=RESET_VECTOR
  - misalign_valid=0, misalign_addr=0, fetch_count=0
  - fetch_valid=0
- BOOT -> RUN unconditionally on the next edge; pc unchanged.
- fetch_valid = (state==RUN) && !stall. A handshake is accepted when fetch_valid && fetch_ready.
- Next-PC priority, evaluated each edge:
  1. trap_valid: pc <= trap_target with low log2(ALIGN_BYTES) bits forced to 0; state <= RUN. Valid from any state, including FAULT and BOOT.
  2. redirect_valid with target aligned: pc <= redirect_target; state <= RUN.
  3. redirect_valid with target % ALIGN_BYTES != 0: pc unchanged; state <= FAULT; misalign_valid <= 1; misalign_addr <= redirect_target.
  4. Accepted handshake and no redirect/trap: pc <= pc_plus.
  5. Otherwise: pc holds.
- Redirect and trap override stall. A pending unaccepted request is abandoned; fetch_valid may drop only because of stall, redirect, trap or reset.
- While fetch_valid=1 and fetch_ready=0, pc is stable unless a redirect or trap occurs.
- misalign_valid is high for exactly one cycle per fault. misalign_addr holds its value until the next fault.
- In FAULT: fetch_valid=0 and redirect_valid is ignored; only trap_valid exits.
- pc_plus and fetch_count wrap modulo 2^XLEN and 2^32 respectively; no saturation.
- fetch_count increments on each accepted handshake, including the handshake in the same cycle a redirect is taken (request was already accepted).

## Timing
- pc, state, misalign_*, fetch_count: registered, updated on posedge clk.
- fetch_valid, pc_plus: combinational from registered state/pc and stall.
- Redirect/trap latency: sampled at edge N; new pc visible after edge N; fetch_valid for it in cycle N+1 if not stalled.
- First fetch request: second cycle after reset deassertion (BOOT consumes one cycle).
- Back-to-back accepts with fetch_ready=1 and stall=0: pc advances by ILEN_BYTES every cycle.
- Reset asserted mid-handshake: immediate return to reset values, no accept counted.

## Structure
- Shared package pc_pkg:
  - pc_state_e (BOOT, RUN, FAULT)
  - default RESET_VECTOR constant
  - ALIGN_BYTES legal values
- Single flat module; alignment check and next-PC mux are inline logic, no sub-module required.

## Test plan
- Reset release, fetch_ready=1, stall=0 -> pc=0x0100_0000 in BOOT; fetch_valid first high next cycle; pc 0x0100_0004, 0x0100_0008 on successive edges; fetch_count 1, 2.
- fetch_ready=0 for 3 cycles with fetch_valid high -> pc held at 0x0100_0008, fetch_count unchanged; ready=1 -> pc 0x0100_000C.
- stall=1 together with redirect_valid, target 0x0100_0100 -> pc=0x0100_0100 next cycle; fetch_valid stays 0 until stall drops.
- redirect_target 0x0100_0102 with ALIGN_BYTES=4 -> misalign_valid one-cycle pulse, misalign_addr=0x0100_0102, pc unchanged, state FAULT, fetch_valid 0; later redirects ignored; trap_target 0x0000_0203 -> pc=0x0000_0200, RUN.
- trap_valid and redirect_valid in the same cycle -> pc=trap_target.
- pc=0xFFFF_FFFC, accepted fetch -> pc wraps to 0x0000_0000; reset pulsed mid-request -> pc=0x0100_0000, fetch_count=0 immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the RV32I fetch-stage program-counter generator:
// FSM state encoding, default reset vector and legal target alignments.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0100_0000;

    localparam int ALIGN_BYTES_HALF = 2;
    localparam int ALIGN_BYTES_WORD = 4;

    function automatic bit is_legal_align(input int bytes);
        return (bytes == ALIGN_BYTES_HALF) || (bytes == ALIGN_BYTES_WORD);
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch address, picks the next one from
// increment / branch redirect / trap redirect, and drives a valid/ready fetch port.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int               ILEN_BYTES   = 4,
    parameter int               ALIGN_BYTES  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            misalign_valid,
    output logic [XLEN-1:0] misalign_addr,
    output logic [31:0]     fetch_count
);

    // Unsupported alignments fall back to word alignment rather than silently disabling the check.
    localparam int              ALIGN_EFF  = is_legal_align(ALIGN_BYTES) ? ALIGN_BYTES : ALIGN_BYTES_WORD;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN_EFF - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(ILEN_BYTES);

    pc_state_e       r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_misalign_valid, w_misalign_valid_nxt;
    logic [XLEN-1:0] r_misalign_addr, w_misalign_addr_nxt;
    logic [31:0]     r_fetch_count;

    logic            w_fetch_valid;
    logic            w_accept;
    logic            w_redirect_misaligned;
    logic [XLEN-1:0] w_pc_plus;

    assign w_fetch_valid         = (r_state == RUN) && !stall;
    assign w_accept              = w_fetch_valid && fetch_ready;
    assign w_redirect_misaligned = (redirect_target & ALIGN_MASK) != '0;
    assign w_pc_plus             = r_pc + PC_STEP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= BOOT;
            r_pc             <= RESET_VECTOR;
            r_misalign_valid <= 1'b0;
            r_misalign_addr  <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_pc             <= w_pc_nxt;
            r_misalign_valid <= w_misalign_valid_nxt;
            r_misalign_addr  <= w_misalign_addr_nxt;
        end
    end

    always_comb begin
        // NOTE: every output takes a default first so no path through the priority chain infers a latch.
        w_state_nxt          = r_state;
        w_pc_nxt             = r_pc;
        w_misalign_valid_nxt = 1'b0;
        w_misalign_addr_nxt  = r_misalign_addr;

        if (r_state == BOOT) begin
            w_state_nxt = RUN;
        end

        if (trap_valid) begin
            w_pc_nxt    = trap_target & ~ALIGN_MASK;
            w_state_nxt = RUN;
        end else if (redirect_valid && (r_state != FAULT)) begin
            if (w_redirect_misaligned) begin
                w_state_nxt          = FAULT;
                w_misalign_valid_nxt = 1'b1;
                w_misalign_addr_nxt  = redirect_target;
            end else begin
                w_pc_nxt    = redirect_target;
                w_state_nxt = RUN;
            end
        end else if (w_accept) begin
            w_pc_nxt = w_pc_plus;
        end
    end

    // An accepted request is counted even when a redirect or trap replaces the next pc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= '0;
        end else if (w_accept) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_valid    = w_fetch_valid;
    assign pc             = r_pc;
    assign pc_plus        = w_pc_plus;
    assign misalign_valid = r_misalign_valid;
    assign misalign_addr  = r_misalign_addr;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the fetch rules.
module tb_pc_gen;

    localparam logic [31:0] RV    = 32'h0100_0000;
    localparam int          ILEN  = 4;
    localparam int          ALIGN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        misalign_valid;
    logic [31:0] misalign_addr;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: "booting" and "faulted" flags instead of a state machine.
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_mis_addr;
    bit          m_mis_pulse;
    bit          m_booting;
    bit          m_faulted;

    pc_gen #(
        .XLEN        (32),
        .RESET_VECTOR(RV),
        .ILEN_BYTES  (ILEN),
        .ALIGN_BYTES (ALIGN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_valid     (trap_valid),
        .trap_target    (trap_target),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .misalign_valid (misalign_valid),
        .misalign_addr  (misalign_addr),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_fetch_valid();
        return !m_booting && !m_faulted && !stall;
    endfunction

    task automatic model_reset();
        m_pc        = RV;
        m_count     = 0;
        m_mis_addr  = 0;
        m_mis_pulse = 0;
        m_booting   = 1;
        m_faulted   = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       pc,                    m_pc);
        check({tag, ".pc_plus"},  pc_plus,               m_pc + ILEN);
        check({tag, ".fvalid"},   32'(fetch_valid),      32'(model_fetch_valid()));
        check({tag, ".mis_v"},    32'(misalign_valid),   32'(m_mis_pulse));
        check({tag, ".mis_addr"}, misalign_addr,         m_mis_addr);
        check({tag, ".count"},    fetch_count,           m_count);
    endtask

    // Drive one cycle of inputs, advance the model by the fetch rules, then compare.
    task automatic step(input bit st, input bit rv, input logic [31:0] rt,
                        input bit tv, input logic [31:0] tt, input bit rdy);
        bit          accepted;
        logic [31:0] n_pc;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        trap_valid      = tv;
        trap_target     = tt;
        fetch_ready     = rdy;
        accepted        = model_fetch_valid() && rdy;
        n_pc            = m_pc;
        m_mis_pulse     = 0;
        if (tv) begin
            n_pc      = tt - (tt % ALIGN);
            m_faulted = 0;
        end else if (rv && !m_faulted) begin
            if ((rt % ALIGN) != 0) begin
                m_faulted   = 1;
                m_mis_pulse = 1;
                m_mis_addr  = rt;
            end else begin
                n_pc = rt;
            end
        end else if (accepted) begin
            n_pc = m_pc + ILEN;
        end
        if (accepted) m_count = m_count + 1;
        m_booting = 0;
        @(posedge clk);
        #1;
        m_pc = n_pc;
        check_all("step");
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 32'h0, 0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        reset           = 0;
        stall           = 0;
        redirect_valid  = 0;
        redirect_target = 0;
        trap_valid      = 0;
        trap_target     = 0;
        fetch_ready     = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        check_all("boot");
    endtask

    // Reset asserted between edges must clear state without waiting for a clock.
    task automatic async_reset_check();
        reset = 0;
        #1;
        model_reset();
        check("areset.pc",    pc,                 RV);
        check("areset.count", fetch_count,        32'h0);
        check("areset.fv",    32'(fetch_valid),   32'h0);
        check("areset.mis_v", 32'(misalign_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        check_all("post_areset");
    endtask

    initial begin
        do_reset();
        check("boot.pc", pc, 32'h0100_0000);
        check("boot.fv", 32'(fetch_valid), 32'h0);

        // First request after BOOT, then back-to-back accepts.
        idle(1);
        check("first.fv", 32'(fetch_valid), 32'h1);
        check("first.pc", pc, 32'h0100_0000);
        idle(1);
        idle(1);
        check("seq.pc",    pc,          32'h0100_0008);
        check("seq.count", fetch_count, 32'd2);

        // Memory back-pressure holds pc.
        for (int i = 0; i < 3; i++) idle(0);
        check("hold.pc",    pc,          32'h0100_0008);
        check("hold.count", fetch_count, 32'd2);
        idle(1);
        check("resume.pc", pc, 32'h0100_000C);

        // Redirect overrides stall; no request while stalled.
        step(1, 1, 32'h0100_0100, 0, 32'h0, 1);
        check("stall_redir.pc", pc, 32'h0100_0100);
        check("stall_redir.fv", 32'(fetch_valid), 32'h0);
        step(1, 0, 32'h0, 0, 32'h0, 1);
        check("stall_hold.pc", pc, 32'h0100_0100);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        check("unstall.fv", 32'(fetch_valid), 32'h1);

        // Misaligned redirect -> FAULT until a trap.
        step(0, 1, 32'h0100_0102, 0, 32'h0, 0);
        check("mis.valid", 32'(misalign_valid), 32'h1);
        check("mis.addr",  misalign_addr,       32'h0100_0102);
        check("mis.pc",    pc,                  32'h0100_0100);
        check("mis.fv",    32'(fetch_valid),    32'h0);
        step(0, 1, 32'h0100_0400, 0, 32'h0, 1);
        check("mis.pulse_end", 32'(misalign_valid), 32'h0);
        check("fault.ignore",  pc,                  32'h0100_0100);
        check("fault.addr",    misalign_addr,       32'h0100_0102);
        step(0, 0, 32'h0, 1, 32'h0000_0203, 1);
        check("trap.pc", pc, 32'h0000_0200);
        check("trap.fv", 32'(fetch_valid), 32'h1);

        // Trap wins over a simultaneous redirect.
        step(0, 1, 32'h0000_2000, 1, 32'h0000_1000, 1);
        check("prio.pc", pc, 32'h0000_1000);

        // Wrap of the address space.
        step(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
        check("wrap.pc_plus", pc_plus, 32'h0000_0000);
        idle(1);
        check("wrap.pc", pc, 32'h0000_0000);

        // Reset in the middle of a pending request.
        idle(0);
        async_reset_check();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bit          st, rv, tv, rdy;
            logic [31:0] rt, tt;
            st  = ($urandom % 4) == 0;
            rdy = ($urandom % 3) != 0;
            rv  = ($urandom % 8) == 0;
            tv  = m_faulted ? (($urandom % 4) == 0) : (($urandom % 16) == 0);
            rt  = $urandom;
            if (($urandom % 3) != 0) rt = rt & 32'hFFFF_FFFC;
            tt  = $urandom;
            if (i == 1000) async_reset_check();
            step(st, rv, rt, tv, tt, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
